// File: rtl/seg_scan_lxy.sv
// seg_scan_lxy: eight-digit multiplexed seven-segment driver with frame-aligned data commit and dead-time blanking
module seg_scan_lxy #(
  parameter int BLANK_CYC = 4
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [2:0]  st,
  input  logic        data_vld,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  output logic        data_rdy,
  output logic [7:0]  an,
  output logic [7:0]  seg
);
  logic [2:0]  st_d_q, st_d_d;
  logic [7:0]  cnt_q, cnt_d, an_q, an_d, seg_q, seg_d;
  logic        pend_q, pend_d;
  logic [31:0] pdata_q, pdata_d, adata_q, adata_d;
  logic [7:0]  pdp_q, pdp_d, adp_q, adp_d;
  logic        plz_q, plz_d, alz_q, alz_d;
  logic        chg, lz_blank;
  logic [3:0]  nib;
  logic [6:0]  hex;
  logic [7:0]  drv_an, drv_seg;

  assign data_rdy = !pend_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign chg      = st != st_d_q;
  assign nib      = adata_q[{st_d_q, 2'b00} +: 4];
  // a digit is a leading zero when it and every nibble above it are zero
  assign lz_blank = alz_q && st_d_q != 3'd0 && (adata_q >> {st_d_q, 2'b00}) == 32'd0;

  always_comb begin
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      default: hex = 7'h0E;
    endcase
  end

  assign drv_an  = ~(8'd1 << st_d_q);
  assign drv_seg = {~adp_q[st_d_q], lz_blank ? 7'h7F : hex};

  always_comb begin
    st_d_d  = st_d_q;
    cnt_d   = cnt_q;
    an_d    = an_q;
    seg_d   = seg_q;
    pend_d  = pend_q;
    pdata_d = pdata_q;
    pdp_d   = pdp_q;
    plz_d   = plz_q;
    adata_d = adata_q;
    adp_d   = adp_q;
    alz_d   = alz_q;
    if (chg) begin
      st_d_d = st;
      cnt_d  = 8'(BLANK_CYC);
      an_d   = 8'hFF;
      if (st_d_q == 3'd7 && st == 3'd0 && pend_q) begin
        adata_d = pdata_q;
        adp_d   = pdp_q;
        alz_d   = plz_q;
        pend_d  = 1'b0;
      end
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
      an_d  = cnt_q == 8'd1 ? drv_an : an_q;
      seg_d = cnt_q == 8'd1 ? drv_seg : seg_q;
    end else begin
      an_d  = drv_an;
      seg_d = drv_seg;
    end
    // a commit and an accept never coincide: commit requires pend, accept requires !pend
    if (data_vld && !pend_q) begin
      pdata_d = data;
      pdp_d   = dp_mask;
      plz_d   = blank_lz;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      st_d_q  <= 3'd0;
      cnt_q   <= 8'd0;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
      pend_q  <= 1'b0;
      pdata_q <= 32'd0;
      pdp_q   <= 8'd0;
      plz_q   <= 1'b0;
      adata_q <= 32'd0;
      adp_q   <= 8'd0;
      alz_q   <= 1'b0;
    end else begin
      st_d_q  <= st_d_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      pend_q  <= pend_d;
      pdata_q <= pdata_d;
      pdp_q   <= pdp_d;
      plz_q   <= plz_d;
      adata_q <= adata_d;
      adp_q   <= adp_d;
      alz_q   <= alz_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_lxy.sv
// tb_seg_scan_lxy: directed self-checking bench for seg_scan_lxy
module tb_seg_scan_lxy;
  localparam int BC = 4;
  logic        sys_clk = 1'b0;
  logic        rst, data_vld, blank_lz, data_rdy;
  logic [2:0]  st;
  logic [31:0] data;
  logic [7:0]  dp_mask, an, seg;
  int tests = 0, fails = 0;

  seg_scan_lxy #(.BLANK_CYC(BC)) dut (
    .sys_clk(sys_clk), .rst(rst), .st(st), .data_vld(data_vld), .data(data),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .data_rdy(data_rdy), .an(an), .seg(seg)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_digit(input logic [2:0] s);
    st = s;
    repeat (BC + 1) tick();
  endtask

  task automatic offer(input logic [31:0] d, input logic [7:0] m, input logic z);
    data = d; dp_mask = m; blank_lz = z; data_vld = 1'b1;
    tick();
    data_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; st = 3'd0; data_vld = 1'b0; data = 32'd0; dp_mask = 8'd0; blank_lz = 1'b0;
    tick(); tick();
    tests++; if (an !== 8'hFF) begin fails++; $display("FAIL rst_an got=%h exp=ff", an); end
    tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL rst_seg got=%h exp=ff", seg); end
    tests++; if (data_rdy !== 1'b1) begin fails++; $display("FAIL rst_rdy got=%b exp=1", data_rdy); end
    rst = 1'b0;
    tick();
    tests++; if (an !== 8'hFE) begin fails++; $display("FAIL first_an got=%h exp=fe", an); end
    tests++; if (seg !== 8'hC0) begin fails++; $display("FAIL first_seg got=%h exp=c0", seg); end
  endtask

  task automatic test_dead_time();
    st = 3'd1;
    for (int i = 0; i < BC; i++) begin
      tick();
      tests++; if (an !== 8'hFF) begin fails++; $display("FAIL dead_an edge=%0d got=%h exp=ff", i, an); end
    end
    tick();
    tests++; if (an !== 8'hFD) begin fails++; $display("FAIL dead_new_an got=%h exp=fd", an); end
    tests++; if (seg !== 8'hC0) begin fails++; $display("FAIL dead_new_seg got=%h exp=c0", seg); end
    st = 3'd2;
    tick(); tick(); tick();
    st = 3'd3;
    for (int i = 0; i < BC; i++) begin
      tick();
      tests++; if (an !== 8'hFF) begin fails++; $display("FAIL restart_an edge=%0d got=%h exp=ff", i, an); end
    end
    tick();
    tests++; if (an !== 8'hF7) begin fails++; $display("FAIL restart_new_an got=%h exp=f7", an); end
  endtask

  task automatic test_handshake();
    offer(32'h1234ABCD, 8'h01, 1'b0);
    tests++; if (data_rdy !== 1'b0) begin fails++; $display("FAIL hs_rdy_low got=%b exp=0", data_rdy); end
    tests++; if (seg !== 8'hC0) begin fails++; $display("FAIL hs_old_seg got=%h exp=c0", seg); end
    offer(32'hFFFFFFFF, 8'hFF, 1'b1);
    tests++; if (data_rdy !== 1'b0) begin fails++; $display("FAIL bp_rdy_low got=%b exp=0", data_rdy); end
    for (int i = 4; i < 8; i++) set_digit(3'(i));
    tests++; if (seg !== 8'hC0) begin fails++; $display("FAIL hs_d7_old got=%h exp=c0", seg); end
    st = 3'd0;
    tick();
    tests++; if (data_rdy !== 1'b1) begin fails++; $display("FAIL hs_rdy_high got=%b exp=1", data_rdy); end
    tests++; if (an !== 8'hFF) begin fails++; $display("FAIL hs_commit_an got=%h exp=ff", an); end
    repeat (BC) tick();
    tests++; if (an !== 8'hFE) begin fails++; $display("FAIL hs_d0_an got=%h exp=fe", an); end
    tests++; if (seg !== 8'h21) begin fails++; $display("FAIL hs_d0_seg got=%h exp=21", seg); end
    set_digit(3'd1);
    tests++; if (seg !== 8'hC6) begin fails++; $display("FAIL hs_d1_seg got=%h exp=c6", seg); end
    set_digit(3'd7);
    tests++; if (an !== 8'h7F) begin fails++; $display("FAIL hs_d7_an got=%h exp=7f", an); end
    tests++; if (seg !== 8'hF9) begin fails++; $display("FAIL hs_d7_seg got=%h exp=f9", seg); end
  endtask

  task automatic test_leading_zero();
    offer(32'h00000050, 8'h00, 1'b1);
    set_digit(3'd7);
    set_digit(3'd0);
    tests++; if (seg !== 8'hC0) begin fails++; $display("FAIL lz_d0 got=%h exp=c0", seg); end
    set_digit(3'd1);
    tests++; if (seg !== 8'h92) begin fails++; $display("FAIL lz_d1 got=%h exp=92", seg); end
    for (int i = 2; i < 8; i++) begin
      set_digit(3'(i));
      tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL lz_d%0d got=%h exp=ff", i, seg); end
    end
    offer(32'h00000000, 8'h00, 1'b1);
    set_digit(3'd0);
    tests++; if (seg !== 8'hC0) begin fails++; $display("FAIL lz0_d0 got=%h exp=c0", seg); end
    for (int i = 1; i < 8; i++) begin
      set_digit(3'(i));
      tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL lz0_d%0d got=%h exp=ff", i, seg); end
    end
  endtask

  task automatic test_reset_mid();
    offer(32'h88888888, 8'hFF, 1'b0);
    st = 3'd6;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    tests++; if (an !== 8'hFF) begin fails++; $display("FAIL mid_an got=%h exp=ff", an); end
    tests++; if (seg !== 8'hFF) begin fails++; $display("FAIL mid_seg got=%h exp=ff", seg); end
    tests++; if (data_rdy !== 1'b1) begin fails++; $display("FAIL mid_rdy got=%b exp=1", data_rdy); end
    st = 3'd0;
    tick();
    rst = 1'b0;
    tick();
    tests++; if (an !== 8'hFE) begin fails++; $display("FAIL mid_rel_an got=%h exp=fe", an); end
    tests++; if (seg !== 8'hC0) begin fails++; $display("FAIL mid_rel_seg got=%h exp=c0", seg); end
    set_digit(3'd7);
    set_digit(3'd0);
    tests++; if (seg !== 8'hC0) begin fails++; $display("FAIL mid_nocommit_d0 got=%h exp=c0", seg); end
    set_digit(3'd7);
    tests++; if (seg !== 8'hC0) begin fails++; $display("FAIL mid_nocommit_d7 got=%h exp=c0", seg); end
  endtask

  initial begin
    test_reset();
    test_dead_time();
    test_handshake();
    test_leading_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
